// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the scan sequencer.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    // A dwell request of zero is promoted to this many cycles.
    localparam int DWELL_MIN = 1;

    // BLANK is only ever entered when SCAN_BLANK_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/rr_next_sel.sv
// Rotating priority search: first set mask bit at or after ptr, circularly.
// wrapped flags a hit that lies numerically below the starting pointer.
module rr_next_sel
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx,
    output logic              wrapped
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [SEL_W-1:0] cand;
        found   = 1'b0;
        idx     = ptr;
        wrapped = 1'b0;
        cand    = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        wrapped = found && (idx < ptr);
    end

endmodule

// File: rtl/scan_sequencer.sv
// Round-robin channel scanner driving a 3-to-8 decoder (sel / sel_en).
// Each requested channel is held for a captured dwell time; gapless hand-off
// between channels by default. Define SCAN_BLANK_EN to insert one blank
// (sel_en low) cycle on every channel-to-channel transition.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  req_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_en,
    output logic               busy,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic               sel_en_d, busy_d, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               stop_q, stop_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [DWELL_W-1:0] dwell_eff;
    logic [SEL_W-1:0]   search_ptr;
    logic               found;
    logic [SEL_W-1:0]   idx;
    logic               wrapped;

    // Zero dwell behaves as a one-cycle dwell.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(DWELL_MIN) : dwell;

    // In IDLE resume from the stored pointer; at a dwell boundary search
    // from the channel after the current one.
    assign search_ptr = (state_q == IDLE) ? ptr_q : sel + SEL_W'(1);

    rr_next_sel u_next (
        .mask    (req_mask),
        .ptr     (search_ptr),
        .found   (found),
        .idx     (idx),
        .wrapped (wrapped)
    );

    // State and output registers; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel     <= '0;
            sel_en  <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            stop_q  <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            sel_en  <= sel_en_d;
            busy    <= busy_d;
            wrap    <= wrap_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            stop_q  <= stop_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel;
        sel_en_d = sel_en;
        busy_d   = busy;
        wrap_d   = 1'b0;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        stop_d   = stop_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                // stop is ignored here, so start+stop starts cleanly.
                if (start && found) begin
                    dwell_d  = dwell_eff;
                    sel_d    = idx;
                    sel_en_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = dwell_eff - DWELL_W'(1);
                    state_d  = DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    ptr_d = search_ptr;
                    if (stop_q || stop || !found) begin
                        // Halt after a full dwell; sel keeps the last channel.
                        state_d  = IDLE;
                        sel_en_d = 1'b0;
                        busy_d   = 1'b0;
                        stop_d   = 1'b0;
                    end else begin
                        sel_d  = idx;
                        // A pass completes when the search passes channel 7.
                        wrap_d = wrapped || (sel == SEL_LAST);
                        cnt_d  = dwell_q - DWELL_W'(1);
`ifdef SCAN_BLANK_EN
                        sel_en_d = 1'b0;
                        state_d  = BLANK;
`endif
                    end
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                // sel already points at the new channel; enable it next.
                if (stop) begin
                    stop_d = 1'b1;
                end
                sel_en_d = 1'b1;
                state_d  = DWELL;
            end
`endif
            default: begin
                state_d  = IDLE;
                sel_en_d = 1'b0;
                busy_d   = 1'b0;
                stop_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer. Expected per-cycle output records
// {busy, sel_en, wrap, sel} are queued by the driver after each start; a
// negedge monitor pops and compares them. Honours SCAN_BLANK_EN.
module tb_scan_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [7:0] req_mask;
    logic [2:0] sel;
    logic       sel_en;
    logic       busy;
    logic       wrap;

    logic [5:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dwell    (dwell),
        .req_mask (req_mask),
        .sel      (sel),
        .sel_en   (sel_en),
        .busy     (busy),
        .wrap     (wrap)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare one queued record per cycle on the falling edge.
    always @(negedge clk) begin
        logic [5:0] e;
        logic [5:0] act;
        if (!rst) begin
            act = {busy, sel_en, wrap, sel};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL cycle_rec @%0t: got busy=%b en=%b wrap=%b sel=%0d expected busy=%b en=%b wrap=%b sel=%0d",
                             $time, act[5], act[4], act[3], act[2:0], e[5], e[4], e[3], e[2:0]);
                end
            end else if (busy) begin
                checks++;
                errors++;
                $display("FAIL unexpected_busy @%0t: got busy=1 sel=%0d expected idle", $time, sel);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One channel visit of n enabled cycles; w is the wrap flag of the
    // transition into it (ignored for the first visit after start).
    task automatic visit(input logic [2:0] s, input int n, input logic w, input bit first);
`ifdef SCAN_BLANK_EN
        if (!first) exp_q.push_back({1'b1, 1'b0, w, s});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b1, 1'b0, s});
`else
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b1, (i == 0) ? (w & !first) : 1'b0, s});
`endif
    endtask

    task automatic idle_rec(input logic [2:0] s);
        exp_q.push_back({1'b0, 1'b0, 1'b0, s});
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Drive a one-cycle start; returns just after it has been sampled.
    task automatic start_scan(input logic [7:0] m, input logic [7:0] d, input logic stp);
        @(posedge clk); #2;
        req_mask = m; dwell = d; start = 1'b1; stop = stp;
        @(posedge clk); #2;
        start = 1'b0; stop = 1'b0;
    endtask

    // Wait until at most rem records (including the current cycle) remain.
    task automatic wait_rem(input int rem);
        int g = 0;
        while (exp_q.size() > rem && g < 300) begin
            @(posedge clk); #2;
            g++;
        end
        if (exp_q.size() > rem) begin
            checks++; errors++;
            $display("FAIL wait_rem_timeout: got %0d records left expected %0d", exp_q.size(), rem);
        end
    endtask

    task automatic stop_at(input int rem);
        wait_rem(rem);
        stop = 1'b1;
        @(posedge clk); #2;
        stop = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d records left expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 8'd0; req_mask = 8'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_sel", {5'd0, sel}, 8'd0);
        chk("rst_sel_en", {7'd0, sel_en}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_wrap", {7'd0, wrap}, 8'd0);
        rst = 1'b0;

        // Sparse mask rotation 2,5,7,2,5 with wrap on 7->2, halted by stop.
        start_scan(8'b1010_0100, 8'd3, 1'b0);
        visit(3'd2, 3, 1'b0, 1'b1);
        visit(3'd5, 3, 1'b0, 1'b0);
        visit(3'd7, 3, 1'b0, 1'b0);
        visit(3'd2, 3, 1'b1, 1'b0);
        visit(3'd5, 3, 1'b0, 1'b0);
        idle_rec(3'd5);
        stop_at(3);
        drain();

        // Zero dwell on a single channel: one-cycle visits, wrap each time.
        reset_dut();
        start_scan(8'h01, 8'd0, 1'b0);
        visit(3'd0, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) visit(3'd0, 1, 1'b1, 1'b0);
        idle_rec(3'd0);
        stop_at(2);
        drain();

        // Stop on cycle 1 of a 4-cycle dwell; a start while busy is ignored.
        reset_dut();
        start_scan(8'h08, 8'd4, 1'b0);
        visit(3'd3, 4, 1'b0, 1'b1);
        idle_rec(3'd3);
        wait_rem(5);
        stop = 1'b1; start = 1'b1; dwell = 8'd9;
        @(posedge clk); #2;
        stop = 1'b0; start = 1'b0;
        drain();

        // start and stop together in IDLE: start wins, stop not latched.
        reset_dut();
        start_scan(8'h10, 8'd2, 1'b1);
        visit(3'd4, 2, 1'b0, 1'b1);
        visit(3'd4, 2, 1'b1, 1'b0);
        idle_rec(3'd4);
        stop_at(2);
        drain();

        // Start with an empty mask stays idle.
        reset_dut();
        start_scan(8'h00, 8'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("empty_busy", {7'd0, busy}, 8'd0);
            chk("empty_sel_en", {7'd0, sel_en}, 8'd0);
            @(posedge clk); #2;
        end

        // Mask cleared mid-dwell: current visit completes, then idle.
        start_scan(8'h06, 8'd3, 1'b0);
        visit(3'd1, 3, 1'b0, 1'b1);
        visit(3'd2, 3, 1'b0, 1'b0);
        idle_rec(3'd2);
        wait_rem(3);
        req_mask = 8'h00;
        drain();

        // Two channels, dwell 2, with an ignored start mid-scan.
        reset_dut();
        start_scan(8'h03, 8'd2, 1'b0);
        visit(3'd0, 2, 1'b0, 1'b1);
        visit(3'd1, 2, 1'b0, 1'b0);
        visit(3'd0, 2, 1'b1, 1'b0);
        visit(3'd1, 2, 1'b0, 1'b0);
        idle_rec(3'd1);
        wait_rem(6);
        start = 1'b1; dwell = 8'd7;
        @(posedge clk); #2;
        start = 1'b0;
        stop_at(2);
        drain();

        // Asynchronous reset on cycle 3 of channel 2, then a fresh start.
        reset_dut();
        start_scan(8'hFF, 8'd5, 1'b0);
        visit(3'd0, 5, 1'b0, 1'b1);
        visit(3'd1, 5, 1'b0, 1'b0);
        visit(3'd2, 5, 1'b0, 1'b0);
        wait_rem(3);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_sel", {5'd0, sel}, 8'd0);
        chk("async_rst_sel_en", {7'd0, sel_en}, 8'd0);
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        chk("async_rst_wrap", {7'd0, wrap}, 8'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        start_scan(8'hFF, 8'd2, 1'b0);
        visit(3'd0, 2, 1'b0, 1'b1);
        visit(3'd1, 2, 1'b0, 1'b0);
        idle_rec(3'd1);
        stop_at(2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
